game_over_ctrl: RTL

//  Round-end sequencer directly upstream of the game-over overlay drawer; produces its game_over_screen enable.
//  - Detects player death and latches the winner.
//  - Holds a death-animation delay, then raises the overlay on a frame boundary so the overlay never tears.
//  - Arms restart after a minimum display time, then issues a one-cycle game_restart pulse.

---
 rtl/game_over_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/game_over_ctrl.sv
// Round-end sequencer: death -> delayed overlay on a frame boundary -> armed restart -> one-cycle game_restart.
// Overlay rises DEATH_DELAY_FRAMES frame_ticks after the death is seen; no backpressure, every input is sampled every cycle.
module game_over_ctrl #(
    parameter int DEATH_DELAY_FRAMES = 60,
    parameter int MIN_SHOW_FRAMES    = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       p1_dead,
    input  logic       p2_dead,
    input  logic       restart_btn,
    output logic       game_over_screen,
    output logic       game_freeze,
    output logic [1:0] winner,
    output logic       game_restart
);

    localparam int MAX_FRAMES = (DEATH_DELAY_FRAMES > MIN_SHOW_FRAMES) ?
                                DEATH_DELAY_FRAMES : MIN_SHOW_FRAMES;
    localparam int CNT_W = $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DEATH_DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] SHOW_MIN   = CNT_W'(MIN_SHOW_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        PLAYING = 2'd0,
        DYING   = 2'd1,
        SHOW    = 2'd2,
        RESTART = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             armed;
    logic             armed_nxt;
    logic             btn_q;
    logic             btn_rise;
    logic             screen_nxt;
    logic             freeze_nxt;
    logic [1:0]       winner_nxt;
    logic             restart_nxt;

    assign btn_rise = restart_btn & ~btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= PLAYING;
            cnt              <= '0;
            armed            <= 1'b0;
            btn_q            <= 1'b0;
            game_over_screen <= 1'b0;
            game_freeze      <= 1'b0;
            winner           <= 2'd0;
            game_restart     <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            armed            <= armed_nxt;
            btn_q            <= restart_btn;
            game_over_screen <= screen_nxt;
            game_freeze      <= freeze_nxt;
            winner           <= winner_nxt;
            game_restart     <= restart_nxt;
        end
    end

    // Deaths seen during the restart pulse are stale: game logic has not cleared them yet.
    always_comb begin
        state_nxt = state;
        case (state)
            PLAYING: if ((p1_dead | p2_dead) && !game_restart) state_nxt = DYING;
            DYING:   if (frame_tick && (cnt == DELAY_LAST))   state_nxt = SHOW;
            SHOW:    if (btn_rise && armed)                   state_nxt = RESTART;
            RESTART: if (frame_tick)                          state_nxt = PLAYING;
            default:                                          state_nxt = PLAYING;
        endcase
    end

    always_comb begin
        cnt_nxt     = cnt;
        armed_nxt   = armed;
        screen_nxt  = game_over_screen;
        freeze_nxt  = game_freeze;
        winner_nxt  = winner;
        restart_nxt = 1'b0;
        case (state)
            PLAYING: begin
                if (state_nxt == DYING) begin
                    cnt_nxt    = '0;
                    winner_nxt = {p1_dead, p2_dead};
                end
            end
            DYING: begin
                // A second death during the animation turns the round into a draw.
                winner_nxt = winner | {p1_dead, p2_dead};
                if (frame_tick) cnt_nxt = cnt + CNT_ONE;
                if (state_nxt == SHOW) begin
                    cnt_nxt    = '0;
                    screen_nxt = 1'b1;
                    freeze_nxt = 1'b1;
                end
            end
            SHOW: begin
                if (frame_tick && (cnt != SHOW_MIN)) cnt_nxt = cnt + CNT_ONE;
                // Requiring a released button before arming stops a held button skipping the screen.
                if ((cnt == SHOW_MIN) && !restart_btn) armed_nxt = 1'b1;
            end
            RESTART: begin
                if (state_nxt == PLAYING) begin
                    screen_nxt  = 1'b0;
                    freeze_nxt  = 1'b0;
                    winner_nxt  = 2'd0;
                    armed_nxt   = 1'b0;
                    restart_nxt = 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

endmodule
